// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with 3-sample majority voting,
// runtime parity (even/odd/none) and 1/2 stop-bit selection, and one-cycle
// DATA_VALID / PAR_ERR / STP_ERR pulses per frame.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined;
// otherwise BREAK is tied low and an all-zero frame reports as an error.

module uart_rx_param #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      RX_IN,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      BUSY,
  output logic                      BREAK
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned PW  = PRESCALE_WIDTH;
  localparam int unsigned BCW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic            armed_q;
  logic            busy_q;
  logic [PW-1:0]   edge_cnt_q;
  logic [PW-1:0]   prescale_q;
  logic [BCW-1:0]  bit_cnt_q;
  logic            par_en_q;
  logic            par_typ_q;
  logic            stop2_q;
  logic [1:0]      smp_q;
  logic [DW-1:0]   shift_q;
  logic [DW-1:0]   p_data_q;
  logic            par_err_q;
  logic            stp_err_q;
  logic            dv_q;
  logic            pe_q;
  logic            se_q;

  logic [PW-1:0]   half;
  logic [PW-1:0]   edge_nxt;
  logic            last_edge;
  logic            at_s0;
  logic            at_s1;
  logic            at_mid;
  logic            bit_val;
  logic            frame_end;
  logic            fin_stp;
  logic            brk_hit;

  // Bit timing and majority decision derived from the latched prescale
  assign half      = prescale_q >> 1;
  assign last_edge = (edge_cnt_q == (prescale_q - PW'(1)));
  assign edge_nxt  = last_edge ? '0 : (edge_cnt_q + PW'(1));
  assign at_s0     = (edge_cnt_q == (half - PW'(2)));
  assign at_s1     = (edge_cnt_q == (half - PW'(1)));
  assign at_mid    = (edge_cnt_q == half);
  assign bit_val   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

  // Final stop-bit resolution: the frame outcome is decided here
  assign frame_end = at_mid && (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
  assign fin_stp   = stp_err_q | ~bit_val;

`ifdef UART_RX_BREAK_DET_EN
  logic zero_q;
  logic brk_q;
  logic break_q;
  logic fin_brk;

  // Break candidate comes from the first stop bit, even in 2-stop mode
  assign fin_brk = (state_q == S_STOP1) ? (zero_q & ~bit_val) : brk_q;
  assign brk_hit = fin_brk;
  assign BREAK   = break_q;

  // Track whether every resolved bit so far in this frame was 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      zero_q  <= 1'b0;
      brk_q   <= 1'b0;
      break_q <= 1'b0;
    end else begin
      break_q <= frame_end & fin_brk;
      if (state_q == S_IDLE) begin
        zero_q <= 1'b1;
        brk_q  <= 1'b0;
      end
      if (((state_q == S_DATA) || (state_q == S_PARITY)) && at_mid && bit_val) begin
        zero_q <= 1'b0;
      end
      if ((state_q == S_STOP1) && at_mid) begin
        brk_q <= zero_q & ~bit_val;
      end
    end
  end
`else
  assign brk_hit = 1'b0;
  assign BREAK   = 1'b0;
`endif

  // Synchroniser, receive FSM, counters, shift register and output pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      armed_q    <= 1'b1;
      busy_q     <= 1'b0;
      edge_cnt_q <= '0;
      prescale_q <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      smp_q      <= 2'b11;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;

      if (at_s0) smp_q[0] <= rx_s_q;
      if (at_s1) smp_q[1] <= rx_s_q;

      case (state_q)
        S_IDLE: begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (!armed_q) begin
            // After a low-ending frame, wait for the line to go high first
            if (rx_s_q) armed_q <= 1'b1;
          end else if (!rx_s_q) begin
            state_q    <= S_START;
            busy_q     <= 1'b1;
            prescale_q <= PRESCALE;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            stop2_q    <= STOP2;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
          end
        end

        S_START: begin
          edge_cnt_q <= edge_nxt;
          if (at_mid && bit_val) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (last_edge) begin
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          edge_cnt_q <= edge_nxt;
          if (at_mid) shift_q <= {bit_val, shift_q[DW-1:1]};
          if (last_edge) begin
            if (bit_cnt_q == BCW'(DW - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? S_PARITY : S_STOP1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end

        S_PARITY: begin
          edge_cnt_q <= edge_nxt;
          if (at_mid) par_err_q <= (bit_val != ((^shift_q) ^ par_typ_q));
          if (last_edge) state_q <= S_STOP1;
        end

        S_STOP1: begin
          edge_cnt_q <= edge_nxt;
          if (at_mid) begin
            if (stop2_q) begin
              stp_err_q <= ~bit_val;
            end else begin
              state_q <= S_DONE;
              armed_q <= bit_val;
            end
          end
          if (stop2_q && last_edge) state_q <= S_STOP2;
        end

        S_STOP2: begin
          edge_cnt_q <= edge_nxt;
          if (at_mid) begin
            state_q <= S_DONE;
            armed_q <= bit_val;
          end
        end

        S_DONE: begin
          edge_cnt_q <= '0;
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Exactly one outcome per completed frame, visible during DONE
      if (frame_end && !brk_hit) begin
        if (fin_stp || par_err_q) begin
          pe_q <= par_err_q;
          se_q <= fin_stp;
        end else begin
          dv_q     <= 1'b1;
          p_data_q <= shift_q;
        end
      end
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (DATA_WIDTH=8, PRESCALE_WIDTH=6).

module tb_uart_rx_param;

  logic       CLK;
  logic       RST;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       RX_IN;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       BUSY;
  logic       BREAK;

  int n_cmp;
  int n_bad;
  int bit_p;

  int dv_cnt;
  int pe_cnt;
  int se_cnt;
  int bk_cnt;
  int busy_cyc;
  logic [7:0] dv_log[$];

  int dv0, pe0, se0, bk0, busy0, qbase;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .RX_IN      (RX_IN),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .BUSY       (BUSY),
    .BREAK      (BREAK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters and received-word log, sampled on the falling edge
  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_log.push_back(P_DATA);
    end
    if (PAR_ERR === 1'b1) pe_cnt = pe_cnt + 1;
    if (STP_ERR === 1'b1) se_cnt = se_cnt + 1;
    if (BREAK === 1'b1) bk_cnt = bk_cnt + 1;
    if (BUSY === 1'b1) busy_cyc = busy_cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX_IN = b;
    idle(bit_p);
  endtask

  // Bit with a one-cycle inverted blip that lands on exactly one of the three samples
  task automatic send_bit_g(input logic b, input int k);
    RX_IN = b;
    idle(k);
    RX_IN = ~b;
    idle(1);
    RX_IN = b;
    idle(bit_p - k - 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_b,
                            input logic s1, input logic s2_on, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_on) send_bit(par_b);
    send_bit(s1);
    if (s2_on) send_bit(s2);
  endtask

  task automatic snap();
    dv0   = dv_cnt;
    pe0   = pe_cnt;
    se0   = se_cnt;
    bk0   = bk_cnt;
    busy0 = busy_cyc;
    qbase = dv_log.size();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RX_IN = 1'b1;
    PRESCALE = 6'd16;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    STOP2 = 1'b0;
    idle(3);
    n_cmp++; if (P_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_p_data got=%h exp=00", P_DATA); end
    n_cmp++; if (DATA_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_dv got=%b exp=0", DATA_VALID); end
    n_cmp++; if (PAR_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_pe got=%b exp=0", PAR_ERR); end
    n_cmp++; if (STP_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_se got=%b exp=0", STP_ERR); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    n_cmp++; if (BREAK !== 1'b0) begin n_bad++; $display("FAIL reset_break got=%b exp=0", BREAK); end
    RST = 1'b0;
    idle(5);
  endtask

  // 0xA5, odd parity -> parity bit 1; config changed mid-frame must be ignored
  task automatic test_good_frame();
    logic [7:0] d;
    d = 8'hA5;
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    bit_p = 16;
    idle(5);
    snap();
    send_bit(1'b0);
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) send_bit_g(d[i], 9);
      else if (i == 5) send_bit_g(d[i], 8);
      else send_bit(d[i]);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    idle(32);
    PRESCALE = 6'd16; PAR_EN = 1'b1;
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL good_dv_pulses got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL good_pe_pulses got=%0d exp=0", pe_cnt - pe0); end
    n_cmp++; if (se_cnt - se0 !== 0) begin n_bad++; $display("FAIL good_se_pulses got=%0d exp=0", se_cnt - se0); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_bad++; $display("FAIL good_p_data got=%h exp=a5", P_DATA); end
    n_cmp++;
    if (dv_log.size() < qbase + 1) begin n_bad++; $display("FAIL good_logged got=none exp=a5"); end
    else if (dv_log[qbase] !== 8'hA5) begin n_bad++; $display("FAIL good_logged got=%h exp=a5", dv_log[qbase]); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL good_busy_idle got=%b exp=0", BUSY); end
  endtask

  task automatic test_parity_err();
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    bit_p = 16;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b1;
    idle(32);
    n_cmp++; if (pe_cnt - pe0 !== 1) begin n_bad++; $display("FAIL par_pe_pulses got=%0d exp=1", pe_cnt - pe0); end
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_bad++; $display("FAIL par_dv_pulses got=%0d exp=0", dv_cnt - dv0); end
    n_cmp++; if (se_cnt - se0 !== 0) begin n_bad++; $display("FAIL par_se_pulses got=%0d exp=0", se_cnt - se0); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_bad++; $display("FAIL par_p_data_hold got=%h exp=a5", P_DATA); end
  endtask

  // 0x07 has three ones: even parity bit is 1
  task automatic test_even_parity();
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    bit_p = 16;
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b1;
    idle(32);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL even_dv_pulses got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL even_pe_pulses got=%0d exp=0", pe_cnt - pe0); end
    n_cmp++; if (P_DATA !== 8'h07) begin n_bad++; $display("FAIL even_p_data got=%h exp=07", P_DATA); end
  endtask

  task automatic test_two_stop();
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
    bit_p = 8;
    idle(8);
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    RX_IN = 1'b1;
    idle(24);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL stop2_ok_dv got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (P_DATA !== 8'h3C) begin n_bad++; $display("FAIL stop2_ok_p_data got=%h exp=3c", P_DATA); end
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    RX_IN = 1'b1;
    idle(24);
    n_cmp++; if (se_cnt - se0 !== 1) begin n_bad++; $display("FAIL stop2_se_pulses got=%0d exp=1", se_cnt - se0); end
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_bad++; $display("FAIL stop2_dv_pulses got=%0d exp=0", dv_cnt - dv0); end
    n_cmp++; if (pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL stop2_pe_pulses got=%0d exp=0", pe_cnt - pe0); end
    n_cmp++; if (P_DATA !== 8'h3C) begin n_bad++; $display("FAIL stop2_p_data_hold got=%h exp=3c", P_DATA); end
  endtask

  task automatic test_glitch();
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    bit_p = 16;
    idle(20);
    snap();
    RX_IN = 1'b0;
    idle(4);
    RX_IN = 1'b1;
    idle(10);
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_back got=%b exp=0", BUSY); end
    n_cmp++; if ((busy_cyc - busy0 > 0) !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_seen got=%0d exp=>0", busy_cyc - busy0); end
    idle(20);
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_bad++; $display("FAIL glitch_dv got=%0d exp=0", dv_cnt - dv0); end
    n_cmp++; if (pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL glitch_pe got=%0d exp=0", pe_cnt - pe0); end
    n_cmp++; if (se_cnt - se0 !== 0) begin n_bad++; $display("FAIL glitch_se got=%0d exp=0", se_cnt - se0); end
  endtask

  // 0x3C and 0xC3 both have four ones: even parity bit 0
  task automatic test_back_to_back();
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    bit_p = 16;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b1;
    idle(40);
    n_cmp++; if (dv_cnt - dv0 !== 2) begin n_bad++; $display("FAIL b2b_dv_pulses got=%0d exp=2", dv_cnt - dv0); end
    n_cmp++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin n_bad++; $display("FAIL b2b_err_pulses got=%0d exp=0", (pe_cnt - pe0) + (se_cnt - se0)); end
    n_cmp++;
    if (dv_log.size() < qbase + 2) begin n_bad++; $display("FAIL b2b_words got=%0d words exp=2", dv_log.size() - qbase); end
    else if (dv_log[qbase] !== 8'h3C || dv_log[qbase+1] !== 8'hC3) begin
      n_bad++; $display("FAIL b2b_words got=%h,%h exp=3c,c3", dv_log[qbase], dv_log[qbase+1]);
    end
    n_cmp++; if (P_DATA !== 8'hC3) begin n_bad++; $display("FAIL b2b_p_data got=%h exp=c3", P_DATA); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h5A;
    PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    bit_p = 16;
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    RX_IN = d[4];
    idle(8);
    RST = 1'b1;
    idle(1);
    n_cmp++; if (P_DATA !== 8'h00) begin n_bad++; $display("FAIL rstmid_p_data got=%h exp=00", P_DATA); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", BUSY); end
    n_cmp++; if ({DATA_VALID, PAR_ERR, STP_ERR, BREAK} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_pulses got=%b exp=0000", {DATA_VALID, PAR_ERR, STP_ERR, BREAK}); end
    RST = 1'b0;
    RX_IN = 1'b1;
    idle(40);
    n_cmp++; if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse got=%0d exp=0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)); end
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b1;
    idle(32);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL rstmid_next_dv got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (P_DATA !== 8'h5A) begin n_bad++; $display("FAIL rstmid_next_p_data got=%h exp=5a", P_DATA); end
  endtask

  // Line stuck low for two frame times: one report, then quiet until line high
  task automatic test_idle_low();
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    bit_p = 8;
    idle(8);
    snap();
    RX_IN = 1'b0;
    idle(160);
    RX_IN = 1'b1;
    idle(24);
`ifdef UART_RX_BREAK_DET_EN
    n_cmp++; if (bk_cnt - bk0 !== 1) begin n_bad++; $display("FAIL low_break_pulses got=%0d exp=1", bk_cnt - bk0); end
    n_cmp++; if (se_cnt - se0 !== 0) begin n_bad++; $display("FAIL low_se_pulses got=%0d exp=0", se_cnt - se0); end
`else
    n_cmp++; if (se_cnt - se0 !== 1) begin n_bad++; $display("FAIL low_se_pulses got=%0d exp=1", se_cnt - se0); end
    n_cmp++; if (bk_cnt - bk0 !== 0) begin n_bad++; $display("FAIL low_break_pulses got=%0d exp=0", bk_cnt - bk0); end
`endif
    n_cmp++; if (dv_cnt - dv0 !== 0) begin n_bad++; $display("FAIL low_dv_pulses got=%0d exp=0", dv_cnt - dv0); end
    n_cmp++; if (pe_cnt - pe0 !== 0) begin n_bad++; $display("FAIL low_pe_pulses got=%0d exp=0", pe_cnt - pe0); end
    snap();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b1;
    idle(24);
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL low_rearm_dv got=%0d exp=1", dv_cnt - dv0); end
    n_cmp++; if (P_DATA !== 8'h81) begin n_bad++; $display("FAIL low_rearm_p_data got=%h exp=81", P_DATA); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; bk_cnt = 0; busy_cyc = 0;
    bit_p = 16;
    RST = 1'b1; RX_IN = 1'b1;
    PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    #1;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_even_parity();
    test_two_stop();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_idle_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
